// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: measurement sequencer for the TDC delay line.
// Each result is the sum of 2^AVG_LOG2 samples. One sample is: launch a pulse,
// wait settle_q cycles, capture the tap vector, popcount it, then wait for the
// line to drain back to all zeros.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i, settle_i   request one averaged measurement / settle cycles (latched at start)
//   launch_o            pulse into the delay line (registered)
//   dl_i                delay-line taps (asynchronous to clk)
//   result_o, valid_o,  accumulated popcount, held with valid_o until ready_i
//   ready_i
//   busy_o              high in every state except IDLE
//   sat_o, err_o        sticky per result: a sample had all taps set / a drain timed out
module tdc_meas_ctrl #(
  parameter int N        = 64,
  parameter int CNT_W    = $clog2(N+1),
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [SETTLE_W-1:0]       settle_i,
  output logic                      launch_o,
  input  logic [N-1:0]              dl_i,
  output logic [CNT_W+AVG_LOG2-1:0] result_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic                      sat_o,
  output logic                      err_o
);
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int SC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SC_W-1:0]     SC_LAST  = SC_W'((1 << AVG_LOG2) - 1);
  // Counter increments on the exit edge, so it reaches 2^SETTLE_W-1 as the
  // drain leaves; the drain therefore lasts 2^SETTLE_W-1 cycles at most.
  localparam logic [SETTLE_W-1:0] TMO_LAST = SETTLE_W'((1 << SETTLE_W) - 2);

  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, SAMPLE, ENCODE, DRAIN, OUT} state_t;

  state_t              state;
  logic [SETTLE_W-1:0] settle_q, cnt, tmo;
  logic [SC_W-1:0]     sample_cnt;
  logic [N-1:0]        cap_q, dl_s1, dl_s2;
  logic                zrun;
  logic [CNT_W-1:0]    pop;
  logic                dl_zero, drain_clean, drain_tmo;

  // Popcount rather than thermometer decode: bubbles in the capture just
  // contribute their ones instead of truncating the code.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + CNT_W'(cap_q[i]);
  end

  // Drain detection looks only at the synchronised taps. The capture itself
  // samples dl_i directly: the line is settled by then, so no edge is in flight.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dl_s1 <= '0;
      dl_s2 <= '0;
    end else begin
      dl_s1 <= dl_i;
      dl_s2 <= dl_s1;
    end

  assign dl_zero     = (dl_s2 == '0);
  assign drain_clean = dl_zero && zrun;
  assign drain_tmo   = !drain_clean && (tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      launch_o   <= 1'b0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      result_o   <= '0;
      sat_o      <= 1'b0;
      err_o      <= 1'b0;
      settle_q   <= '0;
      cnt        <= '0;
      tmo        <= '0;
      zrun       <= 1'b0;
      sample_cnt <= '0;
      cap_q      <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state      <= LAUNCH;
          launch_o   <= 1'b1;
          busy_o     <= 1'b1;
          result_o   <= '0;
          sample_cnt <= '0;
          sat_o      <= 1'b0;
          err_o      <= 1'b0;
          settle_q   <= settle_i;
        end
        LAUNCH: begin
          cnt   <= settle_q;
          state <= (settle_q != '0) ? SETTLE : SAMPLE;
        end
        SETTLE: begin
          cnt <= cnt - SETTLE_W'(1);
          if (cnt == SETTLE_W'(1)) state <= SAMPLE;
        end
        SAMPLE: begin
          cap_q    <= dl_i;
          launch_o <= 1'b0;
          state    <= ENCODE;
        end
        ENCODE: begin
          result_o <= result_o + ACC_W'(pop);
          if (&cap_q) sat_o <= 1'b1;
          tmo   <= '0;
          zrun  <= 1'b0;
          state <= DRAIN;
        end
        DRAIN: begin
          tmo  <= tmo + SETTLE_W'(1);
          zrun <= dl_zero;
          if (drain_tmo) err_o <= 1'b1;
          if (drain_clean || drain_tmo) begin
            if (sample_cnt == SC_LAST) begin
              state   <= OUT;
              valid_o <= 1'b1;
            end else begin
              sample_cnt <= sample_cnt + SC_W'(1);
              launch_o   <= 1'b1;
              state      <= LAUNCH;
            end
          end
        end
        OUT: if (ready_i) begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
